// File: rtl/mb_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mb_tx_pkg
// Brief    : Shared types and default sizes for the mainband TX serializer
//            front end.
// Revision : 1.0 - initial release
// ============================================================================
package mb_tx_pkg;

    localparam int c_data_width = 32;
    localparam int c_cnt_width  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage : mb_tx_pkg
`default_nettype wire

// File: rtl/mb_tx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mb_tx_rr_arb
// Brief    : Combinational round-robin one-hot selector; search starts at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module mb_tx_rr_arb
    import mb_tx_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int PTR_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]   REQ_VALID,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   winner
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_masked;
    logic [NUM_REQ-1:0] w_pool;

    // Requests at or above ptr take precedence; wrap to the full set if none.
    always_comb begin
        w_mask   = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
        w_masked = REQ_VALID & w_mask;
        w_pool   = (|w_masked) ? w_masked : REQ_VALID;
        winner   = w_pool & (~w_pool + NUM_REQ'(1));
    end

endmodule : mb_tx_rr_arb
`default_nettype wire

// File: rtl/mb_tx_ser_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mb_tx_ser_ctrl
// Brief    : Burst arbiter and word sequencer in front of the mainband TX
//            serializer; holds each word for DATA_WIDTH bit-cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mb_tx_ser_ctrl
    import mb_tx_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int CNT_WIDTH  = c_cnt_width,
    parameter int NUM_REQ    = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          ABORT,
    output logic                          SER_EN,
    output logic [DATA_WIDTH-1:0]         P_DATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic                          BUSY,
    output logic                          UNDERRUN
);

    localparam int                   PTR_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_WIDTH-1:0] c_last_bit = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                 r_state;
    logic [CNT_WIDTH-1:0]   r_bit_cnt;
    logic [PTR_WIDTH-1:0]   r_ptr;
    logic                   r_last;

    logic [NUM_REQ-1:0]     w_winner;
    logic [NUM_REQ-1:0]     w_ready;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_sel_last;
    logic                   w_xfer;
    logic                   w_boundary;
    logic [PTR_WIDTH-1:0]   w_ptr_next;

    mb_tx_rr_arb #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_arb (
        .REQ_VALID (REQ_VALID),
        .ptr       (r_ptr),
        .winner    (w_winner)
    );

    assign w_boundary = (r_bit_cnt == c_last_bit);
    assign BUSY       = (r_state != ST_IDLE);

    // Outside IDLE only the current owner (held in GNT) may ever be offered a slot.
    always_comb begin
        w_ready = '0;
        if (!ABORT) begin
            case (r_state)
                ST_IDLE: w_ready = w_winner;
                ST_SEND: if (w_boundary && !r_last) w_ready = GNT;
                ST_HOLD: w_ready = GNT;
                default: w_ready = '0;
            endcase
        end
    end

    assign REQ_READY = w_ready;
    assign w_xfer    = |(REQ_VALID & w_ready);

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        w_ptr_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_ready[i]) begin
                w_sel_data = w_sel_data | REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_last = w_sel_last | REQ_LAST[i];
            end
            if (GNT[i]) begin
                w_ptr_next = PTR_WIDTH'((i + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_ptr     <= '0;
            r_last    <= 1'b0;
            SER_EN    <= 1'b0;
            P_DATA    <= '0;
            GNT       <= '0;
            UNDERRUN  <= 1'b0;
        end else if (ABORT) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            SER_EN    <= 1'b0;
            GNT       <= '0;
            UNDERRUN  <= 1'b0;
        end else begin
            UNDERRUN <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        P_DATA    <= w_sel_data;
                        r_last    <= w_sel_last;
                        GNT       <= w_ready;
                        SER_EN    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + CNT_WIDTH'(1);
                    if (w_boundary) begin
                        if (r_last) begin
                            SER_EN  <= 1'b0;
                            GNT     <= '0;
                            r_ptr   <= w_ptr_next;
                            r_state <= ST_GAP;
                        end else if (w_xfer) begin
                            P_DATA  <= w_sel_data;
                            r_last  <= w_sel_last;
                        end else begin
                            SER_EN   <= 1'b0;
                            UNDERRUN <= 1'b1;
                            r_state  <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_xfer) begin
                        P_DATA    <= w_sel_data;
                        r_last    <= w_sel_last;
                        SER_EN    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SEND;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mb_tx_ser_ctrl
`default_nettype wire
